pll_lock_supervisor: RTL and testbench

- Control-side counterpart of the design's PLL wrapper, running in the 50 MHz reference clock domain.
- Drives the PLL's active-high reset and consumes its asynchronous `locked` status.
- Sequences PLL reset/relock, and enforces a lock-acquire timeout with bounded retries.
- Releases a downstream system reset only after lock has been continuously stable; counts lock-loss events.

---
 rtl/pll_lock_supervisor.sv | 219 +++++++++++++++++++++
 tb/tb_pll_lock_supervisor.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pll_lock_supervisor.sv
// -----------------------------------------------------------------------------
// pll_lock_supervisor
//
// Control-side companion of the PLL wrapper, clocked by the 50 MHz reference.
// It drives the PLL reset, watches the asynchronous lock indication, and retries
// lock acquisition a bounded number of times with a timeout on each attempt.
// The downstream system reset is released only after lock has been stable for
// STABLE_CYCLES consecutive synchronized samples. Lock losses seen in RUN are
// counted with a saturating 8-bit counter.
//
// Ports:
//   refclk        in   reference clock, the only clock
//   rst_n         in   asynchronous active-low reset
//   locked        in   PLL lock status, asynchronous to refclk
//   retry_req     in   one-cycle pulse, restarts sequencing from FAIL
//   pll_rst       out  active-high PLL reset (registered)
//   sys_rst_n     out  active-low downstream reset (registered)
//   ready         out  high only in RUN (registered)
//   fail          out  high only in FAIL (registered)
//   lock_loss_cnt out  saturating count of lock losses seen in RUN
//   state         out  RESET_PLL=0, WAIT_LOCK=1, STABLE=2, RUN=3, FAIL=4
// -----------------------------------------------------------------------------
module pll_lock_supervisor #(
  parameter int unsigned RST_CYCLES    = 16,
  parameter int unsigned LOCK_TIMEOUT  = 50000,
  parameter int unsigned STABLE_CYCLES = 1024,
  parameter int unsigned MAX_RETRIES   = 4
) (
  input  logic       refclk,
  input  logic       rst_n,
  input  logic       locked,
  input  logic       retry_req,
  output logic       pll_rst,
  output logic       sys_rst_n,
  output logic       ready,
  output logic       fail,
  output logic [7:0] lock_loss_cnt,
  output logic [2:0] state
);

  // The shared counter must reach the largest terminal value of any timed state.
  localparam int unsigned MAX_A  = (RST_CYCLES > LOCK_TIMEOUT) ? RST_CYCLES : LOCK_TIMEOUT;
  localparam int unsigned MAX_C  = (MAX_A > STABLE_CYCLES) ? MAX_A : STABLE_CYCLES;
  localparam int unsigned CNT_W  = (MAX_C > 1) ? $clog2(MAX_C) : 1;
  localparam int unsigned RTY_W  = $clog2(MAX_RETRIES + 1);

  typedef enum logic [2:0] {
    ST_RESET_PLL = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_STABLE    = 3'd2,
    ST_RUN       = 3'd3,
    ST_FAIL      = 3'd4
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [RTY_W-1:0] rty_q, rty_d;
  logic [RTY_W-1:0] rty_inc_s;
  logic [7:0]       loss_q, loss_d;
  logic             sync1_q, sync2_q;
  logic             locked_s;
  logic             pll_rst_q, pll_rst_d;
  logic             sys_rst_n_q, sys_rst_n_d;
  logic             ready_q, ready_d;
  logic             fail_q, fail_d;

  // Two-flop synchronizer for the asynchronous lock status.
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= locked;
      sync2_q <= sync1_q;
    end
  end

  assign locked_s  = sync2_q;
  assign rty_inc_s = rty_q + RTY_W'(1);

  // State register together with the counters that move alongside it.
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_RESET_PLL;
      cnt_q   <= {CNT_W{1'b0}};
      rty_q   <= {RTY_W{1'b0}};
      loss_q  <= 8'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rty_q   <= rty_d;
      loss_q  <= loss_d;
    end
  end

  // Next-state, retry and loss-count logic.
  always_comb begin
    state_d = state_q;
    rty_d   = rty_q;
    loss_d  = loss_q;
    case (state_q)
      ST_RESET_PLL: begin
        if (cnt_q == CNT_W'(RST_CYCLES - 1)) begin
          state_d = ST_WAIT_LOCK;
        end else begin
          state_d = ST_RESET_PLL;
        end
      end
      ST_WAIT_LOCK: begin
        // Lock wins over a timeout landing on the same cycle.
        if (locked_s) begin
          state_d = ST_STABLE;
        end else if (cnt_q == CNT_W'(LOCK_TIMEOUT - 1)) begin
          rty_d = rty_inc_s;
          if (rty_inc_s == RTY_W'(MAX_RETRIES)) begin
            state_d = ST_FAIL;
          end else begin
            state_d = ST_RESET_PLL;
          end
        end else begin
          state_d = ST_WAIT_LOCK;
        end
      end
      ST_STABLE: begin
        if (!locked_s) begin
          state_d = ST_WAIT_LOCK;
        end else if (cnt_q == CNT_W'(STABLE_CYCLES - 1)) begin
          state_d = ST_RUN;
          rty_d   = {RTY_W{1'b0}};
        end else begin
          state_d = ST_STABLE;
        end
      end
      ST_RUN: begin
        if (!locked_s) begin
          state_d = ST_RESET_PLL;
          if (loss_q == 8'd255) begin
            loss_d = loss_q;
          end else begin
            loss_d = loss_q + 8'd1;
          end
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_FAIL: begin
        if (retry_req) begin
          state_d = ST_RESET_PLL;
          rty_d   = {RTY_W{1'b0}};
        end else begin
          state_d = ST_FAIL;
        end
      end
      default: begin
        state_d = ST_RESET_PLL;
      end
    endcase

    // Counter restarts on every state entry; it only runs in the timed states.
    if (state_d != state_q) begin
      cnt_d = {CNT_W{1'b0}};
    end else if ((state_q == ST_RUN) || (state_q == ST_FAIL)) begin
      cnt_d = cnt_q;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Output decode from the next state so outputs change on the entering edge.
  always_comb begin
    pll_rst_d   = 1'b1;
    sys_rst_n_d = 1'b0;
    ready_d     = 1'b0;
    fail_d      = 1'b0;
    case (state_d)
      ST_RESET_PLL: begin
        pll_rst_d = 1'b1;
      end
      ST_WAIT_LOCK, ST_STABLE: begin
        pll_rst_d = 1'b0;
      end
      ST_RUN: begin
        pll_rst_d   = 1'b0;
        sys_rst_n_d = 1'b1;
        ready_d     = 1'b1;
      end
      ST_FAIL: begin
        pll_rst_d = 1'b1;
        fail_d    = 1'b1;
      end
      default: begin
        pll_rst_d = 1'b1;
      end
    endcase
  end

  // Output registers.
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      pll_rst_q   <= 1'b1;
      sys_rst_n_q <= 1'b0;
      ready_q     <= 1'b0;
      fail_q      <= 1'b0;
    end else begin
      pll_rst_q   <= pll_rst_d;
      sys_rst_n_q <= sys_rst_n_d;
      ready_q     <= ready_d;
      fail_q      <= fail_d;
    end
  end

  assign pll_rst       = pll_rst_q;
  assign sys_rst_n     = sys_rst_n_q;
  assign ready         = ready_q;
  assign fail          = fail_q;
  assign lock_loss_cnt = loss_q;
  assign state         = state_q;

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// -----------------------------------------------------------------------------
// Testbench for pll_lock_supervisor with small parameters. A timeline model
// (time spent in each phase, sample history of the synchronized lock) predicts
// every output each cycle; directed scenarios add hand-computed checkpoints.
// -----------------------------------------------------------------------------
module tb_pll_lock_supervisor;

  localparam int RST_C  = 4;
  localparam int LOCK_T = 20;
  localparam int STAB   = 8;
  localparam int MAX_R  = 2;

  logic       refclk = 1'b0;
  logic       rst_n;
  logic       locked;
  logic       retry_req;
  logic       pll_rst;
  logic       sys_rst_n;
  logic       ready;
  logic       fail;
  logic [7:0] lock_loss_cnt;
  logic [2:0] state;

  int n_cmp = 0;
  int n_err = 0;

  // Model: phase number, edge of entry, edge counter, lock sample pipeline.
  int m_state, m_entry, m_cyc, m_ones, m_loss, m_events, m_retries;
  bit m_h1, m_h2;

  pll_lock_supervisor #(
    .RST_CYCLES(RST_C), .LOCK_TIMEOUT(LOCK_T),
    .STABLE_CYCLES(STAB), .MAX_RETRIES(MAX_R)
  ) dut (
    .refclk(refclk), .rst_n(rst_n), .locked(locked), .retry_req(retry_req),
    .pll_rst(pll_rst), .sys_rst_n(sys_rst_n), .ready(ready), .fail(fail),
    .lock_loss_cnt(lock_loss_cnt), .state(state)
  );

  always #10 refclk = ~refclk;

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_state = 0; m_entry = 0; m_cyc = 0; m_ones = 0;
    m_loss = 0; m_events = 0; m_retries = 0;
    m_h1 = 1'b0; m_h2 = 1'b0;
  endtask

  task automatic model_edge();
    bit ls;
    int spent;
    int nxt;
    if (!rst_n) begin
      model_reset();
    end else begin
      m_cyc++;
      ls = m_h2;
      m_h2 = m_h1;
      m_h1 = locked;
      m_ones = ls ? m_ones + 1 : 0;
      spent = m_cyc - m_entry;
      nxt = m_state;
      case (m_state)
        0: if (spent == RST_C) nxt = 1;
        1: begin
          if (ls) nxt = 2;
          else if (spent == LOCK_T) begin
            m_retries++;
            nxt = (m_retries == MAX_R) ? 4 : 0;
          end
        end
        2: begin
          if (!ls) nxt = 1;
          else if (spent == STAB) nxt = 3;
        end
        3: begin
          if (!ls) begin
            nxt = 0;
            m_events++;
            if (m_loss < 255) m_loss++;
          end
        end
        4: begin
          if (retry_req) begin
            nxt = 0;
            m_retries = 0;
          end
        end
        default: nxt = 0;
      endcase
      if (nxt == 3) m_retries = 0;
      if (nxt != m_state) m_entry = m_cyc;
      m_state = nxt;
    end
  endtask

  // Per-cycle comparison of every output against the model.
  task automatic check_outputs();
    chk("state", int'(state), m_state);
    chk("pll_rst", int'(pll_rst), (m_state == 0 || m_state == 4) ? 1 : 0);
    chk("sys_rst_n", int'(sys_rst_n), (m_state == 3) ? 1 : 0);
    chk("ready", int'(ready), (m_state == 3) ? 1 : 0);
    chk("fail", int'(fail), (m_state == 4) ? 1 : 0);
    chk("lock_loss_cnt", int'(lock_loss_cnt), m_loss);
    if (sys_rst_n) chk("release_needs_stable_history", (m_ones >= STAB) ? 1 : 0, 1);
  endtask

  task automatic step();
    @(posedge refclk);
    model_edge();
    @(negedge refclk);
    check_outputs();
  endtask

  task automatic wait_state(input int target, input int budget, input string nm);
    for (int i = 0; i < budget && m_state != target; i++) step();
    chk(nm, int'(state), target);
  endtask

  task automatic async_reset();
    #3 rst_n = 1'b0;
    #1;
    chk("async_pll_rst", int'(pll_rst), 1);
    chk("async_sys_rst_n", int'(sys_rst_n), 0);
    chk("async_loss_cnt", int'(lock_loss_cnt), 0);
    chk("async_state", int'(state), 0);
    model_reset();
    step();
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; locked = 1'b1; retry_req = 1'b0;
    model_reset();
    step();
    step();
    chk("reset_state", int'(state), 0);
    chk("reset_pll_rst", int'(pll_rst), 1);
    chk("reset_sys_rst_n", int'(sys_rst_n), 0);

    // Clean lock: RUN on the 13th edge after release.
    rst_n = 1'b1;
    repeat (3) step();
    chk("clean_e3_pll_rst", int'(pll_rst), 1);
    step();
    chk("clean_e4_state", int'(state), 1);
    chk("clean_e4_pll_rst", int'(pll_rst), 0);
    step();
    chk("clean_e5_state", int'(state), 2);
    repeat (7) step();
    chk("clean_e12_sys_rst_n", int'(sys_rst_n), 0);
    step();
    chk("clean_e13_state", int'(state), 3);
    chk("clean_e13_sys_rst_n", int'(sys_rst_n), 1);
    chk("clean_e13_ready", int'(ready), 1);

    // Loss in RUN: sys_rst_n falls on the third edge after locked falls.
    repeat (3) step();
    locked = 1'b0;
    repeat (2) step();
    chk("loss_e2_sys_rst_n", int'(sys_rst_n), 1);
    step();
    chk("loss_e3_sys_rst_n", int'(sys_rst_n), 0);
    chk("loss_e3_pll_rst", int'(pll_rst), 1);
    chk("loss_e3_cnt", int'(lock_loss_cnt), 1);
    locked = 1'b1;

    // Glitch in STABLE after 5 good cycles.
    for (int i = 0; i < 100 && !(m_state == 2 && (m_cyc - m_entry) == 3); i++) step();
    chk("glitch_reach_stable", int'(state), 2);
    locked = 1'b0;
    step();
    locked = 1'b1;
    step();
    step();
    chk("glitch_back_to_wait", int'(state), 1);
    chk("glitch_sys_rst_n", int'(sys_rst_n), 0);
    repeat (8) step();
    chk("glitch_k11_state", int'(state), 2);
    step();
    chk("glitch_k12_state", int'(state), 3);

    // Timeout and retry, then FAIL.
    repeat (2) step();
    locked = 1'b0;
    repeat (3) step();
    chk("to_loss_state", int'(state), 0);
    chk("to_loss_cnt", int'(lock_loss_cnt), 2);
    repeat (24) step();
    chk("to_attempt1_state", int'(state), 0);
    repeat (23) step();
    chk("to_attempt2_wait", int'(state), 1);
    step();
    chk("to_fail_state", int'(state), 4);
    chk("to_fail_fail", int'(fail), 1);
    chk("to_fail_pll_rst", int'(pll_rst), 1);
    for (int i = 0; i < 20; i++) begin
      locked = 1'($urandom_range(0, 1));
      step();
    end
    chk("fail_holds", int'(state), 4);
    retry_req = 1'b1;
    step();
    retry_req = 1'b0;
    chk("retry_state", int'(state), 0);
    chk("retry_fail", int'(fail), 0);
    locked = 1'b1;
    wait_state(3, 100, "retry_relock");

    // Saturation: drive lock-loss events until 256 have occurred.
    for (int e = 0; e < 300 && m_events < 256; e++) begin
      wait_state(3, 100, "sat_reach_run");
      locked = 1'b0;
      step();
      locked = 1'b1;
      for (int i = 0; i < 10 && m_state == 3; i++) step();
      if (m_events == 255 || m_events == 256) chk("sat_cnt", int'(lock_loss_cnt), 255);
    end
    wait_state(3, 100, "sat_relock");

    // Randomized phase: variable-length lock holds, stray retry pulses, rare resets.
    for (int blk = 0; blk < 120; blk++) begin
      locked = ($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0;
      for (int i = 0; i < int'($urandom_range(1, 60)); i++) begin
        retry_req = ($urandom_range(0, 29) == 0) ? 1'b1 : 1'b0;
        if ($urandom_range(0, 49) == 0) locked = ~locked;
        step();
      end
      retry_req = 1'b0;
      if ($urandom_range(0, 39) == 0) async_reset();
    end

    // Async reset mid-RUN.
    locked = 1'b1;
    retry_req = 1'b1;
    step();
    retry_req = 1'b0;
    wait_state(3, 200, "final_reach_run");
    async_reset();
    wait_state(3, 100, "final_relock");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
